// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU sequencer slice.
//   - 4-bit ALU select codes for every legal operation
//   - op_is_legal(): decides whether an opcode may execute and write back
//   - state_e: 2-bit encoding of the sequencer FSM (IDLE / EXEC / WB)
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [3:0] OP_PASSB = 4'b0000;
    localparam logic [3:0] OP_NOT   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SHL   = 4'b0111;
    localparam logic [3:0] OP_SHR   = 4'b1000;
    localparam logic [3:0] OP_SAR   = 4'b1001;

    // Encoding value 2'b11 is unused; the FSM recovers from it to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WB   = 2'b10
    } state_e;

    // True for the eight opcodes the downstream ALU implements.
    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            OP_PASSB, OP_NOT, OP_AND, OP_OR,
            OP_XOR, OP_SHL, OP_SHR, OP_SAR: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command handshake between the issue logic and the
// ALU sequencer.
//   master modport: issue logic (drives cmd_*, observes cmd_ready)
//   slave  modport: sequencer   (samples cmd_*, drives cmd_ready)
// Signals: cmd_valid/cmd_ready handshake, cmd_op (ALU select),
// cmd_dst/cmd_srca/cmd_srcb register addresses, cmd_imm_en/cmd_imm
// immediate B operand.
interface alu_sequencer_if #(
    parameter int ADDR_W = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_dst;
    logic [ADDR_W-1:0] cmd_srca;
    logic [ADDR_W-1:0] cmd_srcb;
    logic              cmd_imm_en;
    logic [7:0]        cmd_imm;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm_en, cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm_en, cmd_imm,
        output cmd_ready
    );
endinterface

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NUM_REGS x DATA_W register file.
//   clk, rst_n          : clock, async active-low clear of every entry
//   we, waddr, wdata    : synchronous write port
//   raddr_a / rdata_a   : combinational read port A
//   raddr_b / rdata_b   : combinational read port B
//   dbg_addr / dbg_data : combinational debug read port
// A write lands at the clock edge, so all read ports show the new value
// from that edge onward.
module regfile_2r1w #(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];

    // Next-state of the storage array: single write port.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage flops with asynchronous clear of every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a  = mem_q[raddr_a];
    assign rdata_b  = mem_q[raddr_b];
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: three-cycle control stage in front of an external
// combinational 8-bit ALU.
//   clk, rst_n : clock, async active-low reset (aborts any operation)
//   cmd        : command handshake (slave side of alu_sequencer_if)
//   alu_sel/alu_a/alu_b : registered ALU inputs, updated only at accept
//   alu_c      : combinational ALU result
//   done/err   : one-cycle completion pulse; err marks an illegal opcode
//   result, flag_z, flag_n : last legal ALU result and its flags
//   dbg_addr/dbg_data      : combinational register-file peek
// Flow: IDLE accepts a command and loads the ALU operands, EXEC captures
// alu_c, WB pulses done and writes the result back. The write-back edge
// precedes the earliest next accept, so back-to-back dependent commands
// read fresh data without forwarding.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int NUM_REGS = 4,   // power of two
    parameter int ADDR_W   = 2    // log2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_sequencer_if.slave    cmd,
    output logic [3:0]        alu_sel,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    input  logic [7:0]        alu_c,
    output logic              done,
    output logic              err,
    output logic [7:0]        result,
    output logic              flag_z,
    output logic              flag_n,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    state_e            state_q,   state_d;
    logic [ADDR_W-1:0] dst_q,     dst_d;
    logic [3:0]        alu_sel_q, alu_sel_d;
    logic [7:0]        alu_a_q,   alu_a_d;
    logic [7:0]        alu_b_q,   alu_b_d;
    logic [7:0]        result_q,  result_d;
    logic              flag_z_q,  flag_z_d;
    logic              flag_n_q,  flag_n_d;
    logic              done_q,    done_d;
    logic              err_q,     err_d;

    logic [7:0]        rd_a;
    logic [7:0]        rd_b;
    logic              wb_en;

    // alu_sel_q doubles as the latched opcode: it only changes at accept.
    assign wb_en = (state_q == WB) && op_is_legal(alu_sel_q);

    regfile_2r1w #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wb_en),
        .waddr    (dst_q),
        .wdata    (result_q),
        .raddr_a  (cmd.cmd_srca),
        .rdata_a  (rd_a),
        .raddr_b  (cmd.cmd_srcb),
        .rdata_b  (rd_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // FSM next-state and datapath next values.
    always_comb begin
        state_d   = state_q;
        dst_d     = dst_q;
        alu_sel_d = alu_sel_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        result_d  = result_q;
        flag_z_d  = flag_z_q;
        flag_n_d  = flag_n_q;
        done_d    = done_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                err_d  = 1'b0;
                if (cmd.cmd_valid) begin
                    // Operands are read here; later cmd_* changes are ignored.
                    dst_d     = cmd.cmd_dst;
                    alu_sel_d = cmd.cmd_op;
                    alu_a_d   = rd_a;
                    alu_b_d   = cmd.cmd_imm_en ? cmd.cmd_imm : rd_b;
                    state_d   = EXEC;
                end else begin
                    state_d   = IDLE;
                end
            end
            EXEC: begin
                if (op_is_legal(alu_sel_q)) begin
                    result_d = alu_c;
                    flag_z_d = (alu_c == 8'h00);
                    flag_n_d = alu_c[7];
                    err_d    = 1'b0;
                end else begin
                    err_d    = 1'b1;
                end
                done_d  = 1'b1;
                state_d = WB;
            end
            WB: begin
                done_d  = 1'b0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                done_d  = 1'b0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // All sequencer state; asynchronous reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dst_q     <= {ADDR_W{1'b0}};
            alu_sel_q <= 4'h0;
            alu_a_q   <= 8'h00;
            alu_b_q   <= 8'h00;
            result_q  <= 8'h00;
            flag_z_q  <= 1'b0;
            flag_n_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dst_q     <= dst_d;
            alu_sel_q <= alu_sel_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            result_q  <= result_d;
            flag_z_q  <= flag_z_d;
            flag_n_q  <= flag_n_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign cmd.cmd_ready = (state_q == IDLE);
    assign alu_sel       = alu_sel_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign result        = result_q;
    assign flag_z        = flag_z_q;
    assign flag_n        = flag_n_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control stage directly upstream of the 8-bit combinational ALU (4-bit select, operands A/B, result C).
- Accepts operation commands over a valid/ready handshake and reads operands from an internal register file.
- Drives the ALU's sel/A/B, captures C, writes the result back to the register file, and reports zero/negative flags.
- Sits between the instruction-issue logic and the ALU; the ALU itself is instantiated outside this block.

Parameters:
- NUM_REGS, 4, register-file depth; must be a power of two.
- ADDR_W, 2, register address width; must equal log2(NUM_REGS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  4  ALU select code.
- cmd_dst  in  ADDR_W  destination register.
- cmd_srca  in  ADDR_W  operand A register.
- cmd_srcb  in  ADDR_W  operand B register.
- cmd_imm_en  in  1  1 = B comes from cmd_imm, not the register file.
- cmd_imm  in  8  immediate B value.
- alu_sel  out  4  to ALU sel.
- alu_a  out  8  to ALU A.
- alu_b  out  8  to ALU B.
- alu_c  in  8  from ALU C (combinational).
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: illegal opcode, no writeback.
- result  out  8  last captured ALU result.
- flag_z  out  1  result == 0.
- flag_n  out  1  result[7].
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  8  combinational read of regfile[dbg_addr].

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - All registers cleared to 0, including every regfile entry.
  - alu_sel, alu_a, alu_b, result, flag_z, flag_n, done and err are all 0.
  - Reset in any state aborts the operation; no regfile write occurs.
- Legal opcodes: 0000 PASSB, 0001 NOT, 0010 AND, 0011 OR, 0100 XOR, 0111 SHL, 1000 SHR, 1001 SAR.
- Illegal opcodes: 0101, 0110, 1010–1111.
- FSM states: IDLE, EXEC, WB.
  - IDLE: cmd_ready = 1. When cmd_valid is high at a rising edge (E0), latch op, dst, srca and B. B is the immediate when cmd_imm_en = 1, otherwise regfile[srcb]. At the same edge, load alu_a = regfile[srca], alu_b = B and alu_sel = op, then go to EXEC. If cmd_valid is low, stay in IDLE and hold all outputs.
  - EXEC: cmd_ready = 0; the ALU settles. At edge E1, result <= alu_c; then go to WB.
    - Legal op: flag_z <= (alu_c == 0), flag_n <= alu_c[7].
    - Illegal op: result and flags are unchanged and err_q <= 1.
  - WB: done = 1 and err = err_q for exactly this cycle. At edge E2, write regfile[dst] <= result only if the op is legal; clear err_q; go to IDLE.
- Latency and throughput:
  - done is asserted in the cycle between E1 and E2.
  - The written value is visible on dbg_data from E2.
  - The next accept is possible at E3, giving one command per 3 cycles.
- alu_sel, alu_a and alu_b hold their last values outside EXEC; they change only at accept.
- Hazards:
  - Operands are read at the accept edge.
  - A back-to-back command whose source equals the previous dst reads the updated value, because the write completes at E2, before the earliest accept at E3.
  - Source, destination and dbg_addr may alias freely.
- cmd_* inputs are sampled only at accept; changes while cmd_ready = 0 are ignored.
- The shift amount is passed unmodified in alu_b; amount interpretation belongs to the ALU.

Decomposition:
- Shared package alu_pkg, containing:
  - 4-bit opcode constants: OP_PASSB, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_SAR.
  - Function op_is_legal(op).
  - State encoding localparams IDLE/EXEC/WB (2-bit).
- One sub-module, regfile_2r1w: NUM_REGS×8, two combinational read ports plus a dbg read port, one synchronous write port, async active-low clear.

Test Plan:
- Reset then load immediates: cmd op=0000, imm_en=1, imm=8'hA3, dst=1 -> done 2 cycles after accept, result=A3, flag_n=1, flag_z=0, dbg_data(1)=A3 after E2.
- SAR with immediate B: r1=A3, op=1001, srca=1, imm=02, dst=2 -> alu_a=A3, alu_b=02, alu_sel=1001; with the ALU model attached, result=E8 and r2=E8.
- XOR to zero: r0=55, r3=55 via loads; op=0100, srca=0, srcb=3, dst=0 -> result=00, flag_z=1, flag_n=0, r0=00.
- Illegal op 0110 with dst=2 and r2=E8 -> done with err=1, r2 stays E8, result/flags unchanged, cmd_ready returns 1 the following cycle.
- Back-to-back hazard: AND writes r1=F3&25=21; the next command, accepted at the earliest cycle, OR srca=1, imm=8B -> alu_a=21, result=AB.
- rst_n pulsed low during EXEC of a write to r3 -> outputs 0, r3=0, state IDLE, no done pulse; the next command completes normally.
